layer_cmd_responder: RTL and testbench

Responder side of the layer-command interface that the inference controller initiates. It accepts one convolution/FC layer command per valid/ready handshake and sequences the 8x8 weight-stationary PE array through every (output-channel tile, input-channel tile) pass: weight preload, pixel streaming and pipeline drain. It then returns a completion response through a second valid/ready handshake. It sits between the inference controller and the PE array / buffer address logic.

---
 rtl/layer_cmd_responder.sv | 184 ++++++++++++++++++
 tb/tb_layer_cmd_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_cmd_responder.sv
// Layer-command responder: accepts one layer command, walks the PE array
// through every (oc tile, ic tile) pass of preload / stream / drain, then
// returns a completion response.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// WLOAD  | preloading weights, one array row per cycle
// STREAM | streaming ifmap pixels through the array
// DRAIN  | letting the systolic pipeline empty, strobes low
// NEXT   | advancing tile indices (ic inner loop, oc outer loop)
// RESP   | response pending until the initiator takes it
module layer_cmd_responder #(
  parameter int ARRAY  = 8,
  parameter int PIX_W  = 12,
  parameter int TILE_W = 4,
  parameter int ROW_W  = $clog2(ARRAY)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [TILE_W-1:0] i_cmd_ic_tiles,
  input  logic [TILE_W-1:0] i_cmd_oc_tiles,
  input  logic [PIX_W-1:0]  i_cmd_pix,
  output logic              o_wload_en,
  output logic [ROW_W-1:0]  o_wload_row,
  output logic              o_stream_en,
  output logic [PIX_W-1:0]  o_pix_addr,
  output logic [TILE_W-1:0] o_ic_idx,
  output logic [TILE_W-1:0] o_oc_idx,
  output logic              o_acc_first,
  output logic              o_acc_last,
  output logic              o_busy,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  input  logic              i_rsp_ready
);

  localparam int DRN_W = $clog2(2*ARRAY);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ARRAY-1);
  localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(2*ARRAY-2);

  typedef enum logic [2:0] {
    IDLE, WLOAD, STREAM, DRAIN, NEXT, RESP
  } state_t;

  state_t              r_state;
  logic [TILE_W-1:0]   r_ic_tiles;
  logic [TILE_W-1:0]   r_oc_tiles;
  logic [PIX_W-1:0]    r_pix;
  logic [DRN_W-1:0]    r_drain_cnt;
  logic                r_wload_en;
  logic [ROW_W-1:0]    r_wload_row;
  logic                r_stream_en;
  logic [PIX_W-1:0]    r_pix_addr;
  logic [TILE_W-1:0]   r_ic_idx;
  logic [TILE_W-1:0]   r_oc_idx;
  logic                r_acc_first;
  logic                r_acc_last;
  logic                r_rsp_err;
  logic                w_cmd_zero;
  logic                w_ic_last;
  logic                w_oc_last;

  assign w_cmd_zero = (i_cmd_ic_tiles == '0) || (i_cmd_oc_tiles == '0) || (i_cmd_pix == '0);
  assign w_ic_last  = (r_ic_idx == r_ic_tiles - TILE_W'(1));
  assign w_oc_last  = (r_oc_idx == r_oc_tiles - TILE_W'(1));

  assign o_cmd_ready = (r_state == IDLE);
  assign o_rsp_valid = (r_state == RESP);
  assign o_busy      = (r_state != IDLE);
  assign o_wload_en  = r_wload_en;
  assign o_wload_row = r_wload_row;
  assign o_stream_en = r_stream_en;
  assign o_pix_addr  = r_pix_addr;
  assign o_ic_idx    = r_ic_idx;
  assign o_oc_idx    = r_oc_idx;
  assign o_acc_first = r_acc_first;
  assign o_acc_last  = r_acc_last;
  assign o_rsp_err   = r_rsp_err;

  // Sequencer: state, latched command fields, counters and registered strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_ic_tiles  <= '0;
      r_oc_tiles  <= '0;
      r_pix       <= '0;
      r_drain_cnt <= '0;
      r_wload_en  <= 1'b0;
      r_wload_row <= '0;
      r_stream_en <= 1'b0;
      r_pix_addr  <= '0;
      r_ic_idx    <= '0;
      r_oc_idx    <= '0;
      r_acc_first <= 1'b0;
      r_acc_last  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            r_ic_tiles <= i_cmd_ic_tiles;
            r_oc_tiles <= i_cmd_oc_tiles;
            r_pix      <= i_cmd_pix;
            r_ic_idx   <= '0;
            r_oc_idx   <= '0;
            if (w_cmd_zero) begin
              r_rsp_err <= 1'b1;
              r_state   <= RESP;
            end else begin
              r_rsp_err   <= 1'b0;
              r_wload_en  <= 1'b1;
              r_wload_row <= '0;
              r_state     <= WLOAD;
            end
          end
        end
        WLOAD: begin
          if (r_wload_row == ROW_LAST) begin
            r_wload_en  <= 1'b0;
            r_wload_row <= '0;
            r_stream_en <= 1'b1;
            r_pix_addr  <= '0;
            r_acc_first <= (r_ic_idx == '0);
            r_acc_last  <= w_ic_last;
            r_state     <= STREAM;
          end else begin
            r_wload_row <= r_wload_row + ROW_W'(1);
          end
        end
        STREAM: begin
          if (r_pix_addr == r_pix - PIX_W'(1)) begin
            r_stream_en <= 1'b0;
            r_pix_addr  <= '0;
            r_acc_first <= 1'b0;
            r_acc_last  <= 1'b0;
            r_drain_cnt <= DRAIN_INIT;
            r_state     <= DRAIN;
          end else begin
            r_pix_addr <= r_pix_addr + PIX_W'(1);
          end
        end
        DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= NEXT;
          end else begin
            r_drain_cnt <= r_drain_cnt - DRN_W'(1);
          end
        end
        NEXT: begin
          if (!w_ic_last) begin
            r_ic_idx   <= r_ic_idx + TILE_W'(1);
            r_wload_en <= 1'b1;
            r_state    <= WLOAD;
          end else begin
            // oc index steps past the final tile on the last pass; that value is what RESP shows
            r_ic_idx <= '0;
            r_oc_idx <= r_oc_idx + TILE_W'(1);
            if (w_oc_last) begin
              r_state <= RESP;
            end else begin
              r_wload_en <= 1'b1;
              r_state    <= WLOAD;
            end
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_ic_idx   <= '0;
            r_oc_idx   <= '0;
            r_ic_tiles <= '0;
            r_oc_tiles <= '0;
            r_pix      <= '0;
            r_rsp_err  <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_cmd_responder.sv
module tb_layer_cmd_responder;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_ic;
  logic [3:0]  cmd_oc;
  logic [11:0] cmd_pix;
  logic        wload_en;
  logic [2:0]  wload_row;
  logic        stream_en;
  logic [11:0] pix_addr;
  logic [3:0]  ic_idx;
  logic [3:0]  oc_idx;
  logic        acc_first;
  logic        acc_last;
  logic        busy;
  logic        rsp_valid;
  logic        rsp_err;
  logic        rsp_ready;

  int n_chk  = 0;
  int n_fail = 0;

  layer_cmd_responder dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_ic_tiles (cmd_ic),
    .i_cmd_oc_tiles (cmd_oc),
    .i_cmd_pix      (cmd_pix),
    .o_wload_en     (wload_en),
    .o_wload_row    (wload_row),
    .o_stream_en    (stream_en),
    .o_pix_addr     (pix_addr),
    .o_ic_idx       (ic_idx),
    .o_oc_idx       (oc_idx),
    .o_acc_first    (acc_first),
    .o_acc_last     (acc_last),
    .o_busy         (busy),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_err      (rsp_err),
    .i_rsp_ready    (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout:
  // {wload_en, wload_row[2:0], stream_en, pix_addr[11:0], ic_idx[3:0], oc_idx[3:0],
  //  acc_first, acc_last, busy, rsp_valid, rsp_err, cmd_ready}
  function automatic logic [30:0] pack(bit we, int row, bit se, int pa, int ic, int oc,
                                       bit f, bit l, bit b, bit rv, bit re, bit cr);
    return {we, 3'(row), se, 12'(pa), 4'(ic), 4'(oc), f, l, b, rv, re, cr};
  endfunction

  function automatic logic [30:0] sample();
    return {wload_en, wload_row, stream_en, pix_addr, ic_idx, oc_idx,
            acc_first, acc_last, busy, rsp_valid, rsp_err, cmd_ready};
  endfunction

  function automatic logic [30:0] idle_vec();
    return pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // Expected outputs in cycle c after the accept edge (c=1 is the first cycle after it).
  function automatic logic [30:0] model(int ic_t, int oc_t, int pix, int c);
    int len, passes, pass, off, ic, oc;
    if (ic_t == 0 || oc_t == 0 || pix == 0)
      return pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    len    = 24 + pix;
    passes = ic_t * oc_t;
    if (c - 1 < passes * len) begin
      pass = (c - 1) / len;
      off  = (c - 1) % len;
      ic   = pass % ic_t;
      oc   = pass / ic_t;
      if (off < 8)
        return pack(1, off, 0, 0, ic, oc, 0, 0, 1, 0, 0, 0);
      else if (off < 8 + pix)
        return pack(0, 0, 1, off - 8, ic, oc, ic == 0, ic == ic_t - 1, 1, 0, 0, 0);
      else
        return pack(0, 0, 0, 0, ic, oc, 0, 0, 1, 0, 0, 0);
    end
    return pack(0, 0, 0, 0, 0, oc_t, 0, 0, 1, 1, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command from an IDLE negedge, check every cycle through the response,
  // then check the IDLE cycle that follows. With hold set, cmd_valid stays high
  // after acceptance carrying the (hic,hoc,hpix) fields.
  task automatic run_cmd(input int ic, input int oc, input int pix, input int wait_c,
                         input int lat, input bit hold, input int hic, input int hoc,
                         input int hpix, input string name);
    int first;
    chk($sformatf("%s_cmd_ready", name), {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_ic    = 4'(ic);
    cmd_oc    = 4'(oc);
    cmd_pix   = 12'(pix);
    rsp_ready = (wait_c == 0);
    @(posedge clk);
    first = 0;
    for (int c = 1; c <= lat + wait_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin
          cmd_ic  = 4'(hic);
          cmd_oc  = 4'(hoc);
          cmd_pix = 12'(hpix);
        end else begin
          cmd_valid = 1'b0;
          cmd_ic    = 4'd15;
          cmd_oc    = 4'd15;
          cmd_pix   = 12'd4095;
        end
      end
      chk($sformatf("%s_c%0d", name, c), {1'b0, sample()}, {1'b0, model(ic, oc, pix, c)});
      if (rsp_valid && first == 0) first = c;
      if (c == lat + wait_c) rsp_ready = 1'b1;
    end
    chk($sformatf("%s_rsp_latency", name), first, lat);
    @(negedge clk);
    chk($sformatf("%s_idle_after", name), {1'b0, sample()}, {1'b0, idle_vec()});
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    int ic;
    int oc;
    int pix;
    int wait_c;
    int lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    // lat = 1 + ic*oc*(24+pix) for legal commands, 1 for illegal ones
    tbl[0] = '{ic: 1, oc: 1, pix: 4,  wait_c: 0, lat: 29};
    tbl[1] = '{ic: 2, oc: 3, pix: 10, wait_c: 0, lat: 205};
    tbl[2] = '{ic: 1, oc: 1, pix: 0,  wait_c: 0, lat: 1};
    tbl[3] = '{ic: 0, oc: 1, pix: 5,  wait_c: 0, lat: 1};
    tbl[4] = '{ic: 1, oc: 0, pix: 5,  wait_c: 0, lat: 1};
    tbl[5] = '{ic: 1, oc: 2, pix: 1,  wait_c: 3, lat: 51};
    tbl[6] = '{ic: 3, oc: 1, pix: 2,  wait_c: 0, lat: 79};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_ic    = '0;
    cmd_oc    = '0;
    cmd_pix   = '0;
    rsp_ready = 1'b0;
    #1;
    chk("reset_state", {1'b0, sample()}, {1'b0, idle_vec()});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", {1'b0, sample()}, {1'b0, idle_vec()});

    for (int i = 0; i < 7; i++)
      run_cmd(tbl[i].ic, tbl[i].oc, tbl[i].pix, tbl[i].wait_c, tbl[i].lat,
              1'b0, 0, 0, 0, $sformatf("vec%0d", i));

    // Backpressure for 20 cycles with a second command held on cmd_valid throughout;
    // it must be taken only at the first IDLE edge.
    run_cmd(2, 1, 3, 20, 55, 1'b1, 1, 1, 2, "bp_first");
    run_cmd(1, 1, 2, 0, 27, 1'b0, 0, 0, 0, "bp_held");

    // Reset in the middle of STREAM, between clock edges.
    cmd_valid = 1'b1;
    cmd_ic    = 4'd1;
    cmd_oc    = 4'd1;
    cmd_pix   = 12'd20;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      chk($sformatf("rst_pre_c%0d", c), {1'b0, sample()}, {1'b0, model(1, 1, 20, c)});
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {1'b0, sample()}, {1'b0, idle_vec()});
    @(negedge clk);
    chk("reset_held", {1'b0, sample()}, {1'b0, idle_vec()});
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_rsp_after_reset", {1'b0, sample()}, {1'b0, idle_vec()});
    run_cmd(1, 1, 1, 0, 26, 1'b0, 0, 0, 0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
